// File: rtl/axis_pkt_select_mux.sv
// N:1 AXI-Stream packet multiplexer with a register-controlled select that only
// switches inputs on packet boundaries, plus a forwarded-packet counter.
module axis_pkt_select_mux #(
    parameter  int WIDTH      = 64,
    parameter  int NUM_INPUTS = 2,
    localparam int SEL_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SEL_W-1:0]            sel,
    input  logic [NUM_INPUTS*WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_INPUTS-1:0]       s_axis_tlast,
    input  logic [NUM_INPUTS-1:0]       s_axis_tvalid,
    output logic [NUM_INPUTS-1:0]       s_axis_tready,
    output logic [WIDTH-1:0]            m_axis_tdata,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [SEL_W-1:0]            cur_sel,
    output logic                        busy,
    output logic [31:0]                 pkt_count
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PASS = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic             m_last_q, m_last_d;
    logic             m_valid_q, m_valid_d;
    logic [31:0]      pkt_count_q, pkt_count_d;

    logic [SEL_W-1:0] eff;
    logic             load_ok;
    logic             in_valid;
    logic             in_last;
    logic [WIDTH-1:0] in_data;
    logic             in_hs;

    // Input side: route the effective input; an out-of-range select matches no
    // input, so every tready stays low and nothing is accepted.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the block
        // leaves it unassigned, which would otherwise infer a latch.
        s_axis_tready = '0;
        in_valid      = 1'b0;
        in_last       = 1'b0;
        in_data       = '0;
        eff           = (state_q == ST_PASS) ? cur_sel_q : sel;
        load_ok       = !m_valid_q || m_axis_tready;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (int'(eff) == i) begin
                s_axis_tready[i] = load_ok && rst_n;
                in_valid         = s_axis_tvalid[i];
                in_last          = s_axis_tlast[i];
                in_data          = s_axis_tdata[i*WIDTH +: WIDTH];
            end
        end
        in_hs = in_valid && load_ok;
    end

    always_comb begin
        state_d     = state_q;
        cur_sel_d   = cur_sel_q;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;
        m_valid_d   = m_valid_q;
        pkt_count_d = pkt_count_q;

        if (state_q == ST_IDLE) begin
            cur_sel_d = sel;
        end
        if (in_hs) begin
            state_d   = in_last ? ST_IDLE : ST_PASS;
            m_data_d  = in_data;
            m_last_d  = in_last;
            m_valid_d = 1'b1;
        end else if (m_valid_q && m_axis_tready) begin
            m_valid_d = 1'b0;
        end
        if (m_valid_q && m_axis_tready && m_last_q) begin
            pkt_count_d = pkt_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cur_sel_q   <= '0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            m_valid_q   <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            cur_sel_q   <= cur_sel_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            m_valid_q   <= m_valid_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tvalid = m_valid_q;
    assign cur_sel       = cur_sel_q;
    assign busy          = (state_q == ST_PASS);
    assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_axis_pkt_select_mux.sv
// Directed and randomized bench for axis_pkt_select_mux (3 inputs, 64-bit data);
// random traffic is checked against a packet-stream reference model.
module tb_axis_pkt_select_mux;

    localparam int W  = 64;
    localparam int N  = 3;
    localparam int SW = 2;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } word_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [SW-1:0]   sel = '0;
    logic [N*W-1:0]  s_tdata = '0;
    logic [N-1:0]    s_tlast = '0;
    logic [N-1:0]    s_tvalid = '0;
    logic [N-1:0]    s_tready;
    logic [W-1:0]    m_tdata;
    logic            m_tlast;
    logic            m_tvalid;
    logic            m_tready = 1'b0;
    logic [SW-1:0]   cur_sel;
    logic            busy;
    logic [31:0]     pkt_count;

    int    n_checks = 0;
    int    n_errors = 0;
    int    busy_cycles;
    int    exp_pkts;
    int    k;
    int    len;
    int    cyc;
    bit    src_v;
    word_t w;
    word_t src_q[$];
    word_t exp_q[$];

    // Backpressure table: per-cycle output ready, driven input word (-1 none),
    // expected input ready, expected output valid and output word index.
    int bp_mr[8]   = '{1, 1, 0, 0, 1, 1, 1, 1};
    int bp_idx[8]  = '{0, 1, 2, 2, 2, 3, -1, -1};
    int bp_rdy[8]  = '{1, 1, 0, 0, 1, 1, 1, 1};
    int bp_ov[8]   = '{0, 1, 1, 1, 1, 1, 1, 0};
    int bp_od[8]   = '{0, 0, 1, 1, 1, 2, 3, 0};

    axis_pkt_select_mux #(
        .WIDTH      (W),
        .NUM_INPUTS (N)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sel           (sel),
        .s_axis_tdata  (s_tdata),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .cur_sel       (cur_sel),
        .busy          (busy),
        .pkt_count     (pkt_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_in(input int i, input logic v, input logic [W-1:0] d, input logic l);
        s_tvalid[i]         = v;
        s_tdata[i*W +: W]   = d;
        s_tlast[i]          = l;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values, with inputs valid to show tready is still held low.
        s_tvalid = '1;
        m_tready = 1'b1;
        #2;
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_cur_sel", cur_sel, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_tready", s_tready, 0);
        s_tvalid = '0;
        #20;
        rst_n = 1'b1;
        tick();

        // 4-word packet on input 0 while input 1 is valid throughout.
        sel = 2'd0;
        drive_in(1, 1'b1, 64'hB1, 1'b0);
        busy_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            drive_in(0, 1'b1, 64'hA0 + 64'(i), i == 3);
            @(negedge clk);
            check("t1_rdy0", s_tready[0], 1);
            check("t1_rdy1", s_tready[1], 0);
            if (i > 0) begin
                check("t1_valid", m_tvalid, 1);
                check("t1_data", m_tdata, 64'hA0 + 64'(i) - 64'd1);
                check("t1_last", m_tlast, 0);
            end
            if (busy) busy_cycles++;
            tick();
        end
        drive_in(0, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("t1_data_last", m_tdata, 64'hA3);
        check("t1_tlast", m_tlast, 1);
        check("t1_rdy1_end", s_tready[1], 0);
        if (busy) busy_cycles++;
        tick();
        @(negedge clk);
        check("t1_valid_drop", m_tvalid, 0);
        check("t1_pkt_count", pkt_count, 1);
        check("t1_busy_cycles", 64'(busy_cycles), 3);
        tick();

        // Select changes mid-packet; switch happens right after the boundary.
        drive_in(1, 1'b1, 64'hD0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) sel = 2'd1;
            drive_in(0, 1'b1, 64'hC0 + 64'(i), i == 4);
            @(negedge clk);
            check("t3_rdy0", s_tready[0], 1);
            check("t3_rdy1", s_tready[1], 0);
            if (i > 0) check("t3_data", m_tdata, 64'hC0 + 64'(i) - 64'd1);
            tick();
        end
        drive_in(0, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("t3_switch_rdy1", s_tready[1], 1);
        check("t3_switch_rdy0", s_tready[0], 0);
        check("t3_data_c4", m_tdata, 64'hC4);
        check("t3_last_c4", m_tlast, 1);
        tick();
        drive_in(1, 1'b1, 64'hD1, 1'b1);
        @(negedge clk);
        check("t3_rdy1_d1", s_tready[1], 1);
        check("t3_data_d0", m_tdata, 64'hD0);
        check("t3_valid_d0", m_tvalid, 1);
        check("t3_cur_sel", cur_sel, 1);
        check("t3_pkt_count_2", pkt_count, 2);
        tick();
        drive_in(1, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("t3_data_d1", m_tdata, 64'hD1);
        check("t3_last_d1", m_tlast, 1);
        tick();
        @(negedge clk);
        check("t3_pkt_count_3", pkt_count, 3);
        check("t3_valid_drop", m_tvalid, 0);
        tick();

        // Output backpressure during a 4-word packet on input 0.
        sel = 2'd0;
        for (int i = 0; i < 8; i++) begin
            m_tready = bp_mr[i][0];
            if (bp_idx[i] >= 0)
                drive_in(0, 1'b1, 64'hE0 + 64'(bp_idx[i]), bp_idx[i] == 3);
            else
                drive_in(0, 1'b0, '0, 1'b0);
            @(negedge clk);
            check("t4_rdy0", s_tready[0], 64'(bp_rdy[i]));
            check("t4_valid", m_tvalid, 64'(bp_ov[i]));
            if (bp_ov[i] == 1) begin
                check("t4_data", m_tdata, 64'hE0 + 64'(bp_od[i]));
                check("t4_last", m_tlast, 64'(bp_od[i] == 3));
            end
            tick();
        end
        @(negedge clk);
        check("t4_pkt_count", pkt_count, 4);
        tick();

        // Reset in the middle of a 6-word packet.
        m_tready = 1'b1;
        drive_in(0, 1'b1, 64'hF0, 1'b0);
        tick();
        drive_in(0, 1'b1, 64'hF1, 1'b0);
        tick();
        drive_in(0, 1'b1, 64'hF2, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t5_tvalid", m_tvalid, 0);
        check("t5_tdata", m_tdata, 0);
        check("t5_tlast", m_tlast, 0);
        check("t5_busy", busy, 0);
        check("t5_cur_sel", cur_sel, 0);
        check("t5_pkt_count", pkt_count, 0);
        check("t5_tready", s_tready, 0);
        drive_in(0, 1'b0, '0, 1'b0);
        sel = 2'd2;
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        drive_in(2, 1'b1, 64'h60, 1'b0);
        @(negedge clk);
        check("t5_rdy2", s_tready[2], 1);
        tick();
        drive_in(2, 1'b1, 64'h61, 1'b1);
        @(negedge clk);
        check("t5_data_g0", m_tdata, 64'h60);
        check("t5_last_g0", m_tlast, 0);
        tick();
        drive_in(2, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("t5_data_g1", m_tdata, 64'h61);
        check("t5_last_g1", m_tlast, 1);
        tick();
        @(negedge clk);
        check("t5_pkt_count_new", pkt_count, 1);
        tick();

        // Out-of-range select blocks all traffic.
        sel = 2'd3;
        for (int i = 0; i < N; i++) drive_in(i, 1'b1, 64'h5A00 + 64'(i), 1'b1);
        for (int i = 0; i < 20; i++) begin
            m_tready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("t6_tvalid", m_tvalid, 0);
            check("t6_tready", s_tready, 0);
            tick();
        end

        // Randomized phases: the output must be exactly the selected input's
        // packet stream, in order, with no other input ever accepted.
        exp_pkts = 0;
        for (int p = 0; p < 6; p++) begin
            k = int'($urandom_range(0, N - 1));
            sel = k[SW-1:0];
            src_q.delete();
            exp_q.delete();
            for (int n = 0; n < 3; n++) begin
                len = int'($urandom_range(1, 5));
                for (int j = 0; j < len; j++) begin
                    w.data = {$urandom, $urandom};
                    w.last = (j == len - 1);
                    src_q.push_back(w);
                    exp_q.push_back(w);
                end
                exp_pkts++;
            end
            for (int i = 0; i < N; i++)
                if (i != k) drive_in(i, 1'b1, {32'hDEAD0000, i}, 1'($urandom_range(0, 1)));
            src_v = 1'b0;
            cyc = 0;
            while (exp_q.size() > 0 && cyc < 2000) begin
                if (!src_v && src_q.size() > 0 && $urandom_range(0, 3) != 0) src_v = 1'b1;
                if (src_v) drive_in(k, 1'b1, src_q[0].data, src_q[0].last);
                else       drive_in(k, 1'b0, '0, 1'b0);
                m_tready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                for (int i = 0; i < N; i++)
                    if (i != k) check("rnd_rdy_other", s_tready[i], 0);
                if (src_v && s_tready[k]) begin
                    void'(src_q.pop_front());
                    src_v = 1'b0;
                end
                if (m_tvalid && m_tready) begin
                    w = exp_q.pop_front();
                    check("rnd_data", m_tdata, w.data);
                    check("rnd_last", m_tlast, w.last);
                end
                tick();
                cyc++;
            end
            if (exp_q.size() != 0) check("rnd_timeout_words_left", 64'(exp_q.size()), 0);
            drive_in(k, 1'b0, '0, 1'b0);
        end
        s_tvalid = '0;
        m_tready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rnd_pkt_count", pkt_count, 64'(1 + exp_pkts));
        check("rnd_final_valid", m_tvalid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
